// File: rtl/rotate_imm_encoder.sv
// Iterative search for the {rot4, imm8} immediate encoding of a 32-bit constant.
// The work register is rotated left two bits per cycle until its value fits in the low byte.
module rotate_imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] shift_operand,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [3:0]  rot_q, rot_d;
  logic        valid_q, valid_d;
  logic [11:0] operand_q, operand_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      work_q    <= 32'd0;
      rot_q     <= 4'd0;
      valid_q   <= 1'b0;
      operand_q <= 12'h000;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rot_q     <= rot_d;
      valid_q   <= valid_d;
      operand_q <= operand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rot_d     = rot_q;
    valid_d   = valid_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEARCH;
          work_d  = value;
          rot_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        // A fit is tested before the rot==15 give-up, so the last rotation can still match.
        if (work_q[31:8] == 24'd0) begin
          operand_d = {rot_q, work_q[7:0]};
          valid_d   = 1'b1;
          state_d   = S_DONE;
        end else if (rot_q == 4'd15) begin
          operand_d = 12'h000;
          valid_d   = 1'b0;
          state_d   = S_DONE;
        end else begin
          work_d = {work_q[29:0], work_q[31:30]};
          rot_d  = rot_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q == S_SEARCH);
  assign done          = (state_q == S_DONE);
  assign valid         = valid_q;
  assign shift_operand = operand_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rotate_imm_encoder.sv
// Bench for rotate_imm_encoder: directed vectors, back-to-back/ignored start, reset abort,
// then randomized traffic compared every cycle against a latency/result model.
module tb_rotate_imm_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [11:0] shift_operand;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  rotate_imm_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .shift_operand (shift_operand),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Smallest rot such that some imm8 rotated right by 2*rot reproduces v.
  task automatic encode(input logic [31:0] v, output bit ok, output logic [11:0] op,
                        output int lat);
    logic [31:0] cand;
    ok  = 0;
    op  = 12'h000;
    lat = 16;
    for (int k = 0; k < 16; k++) begin
      cand = ror32(v, 32 - 2 * k);
      if (ror32({24'd0, cand[7:0]}, 2 * k) == v) begin
        ok  = 1;
        op  = {k[3:0], cand[7:0]};
        lat = k + 1;
        return;
      end
    end
  endtask

  logic        m_busy = 0;
  logic        m_done = 0;
  logic        m_valid = 0;
  logic [11:0] m_op = 12'h000;
  int          m_cnt = 0;
  bit          p_ok;
  logic [11:0] p_op;
  int          p_lat;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  = 0;
      m_done  = 0;
      m_valid = 0;
      m_op    = 12'h000;
      m_cnt   = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy  = 0;
        m_done  = 1;
        m_valid = p_ok;
        m_op    = p_op;
      end
    end else begin
      m_done = 0;
      if (start) begin
        encode(value, p_ok, p_op, p_lat);
        m_busy = 1;
        m_cnt  = p_lat;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("shift_operand", {20'd0, shift_operand}, {20'd0, m_op});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_one(input logic [31:0] v, input logic [11:0] exp_op,
                         input logic exp_valid, input int exp_lat);
    int cyc;
    bit got;
    @(posedge clk); #1;
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    value = $urandom();
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (done) got = 1;
      else cyc++;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", cyc, exp_lat);
      chk("dir_valid", {31'd0, valid}, {31'd0, exp_valid});
      chk("dir_operand", {20'd0, shift_operand}, {20'd0, exp_op});
    end
  endtask

  function automatic logic [31:0] rand_value();
    logic [31:0] imm;
    int r;
    imm = {24'd0, 8'($urandom())};
    r = $urandom_range(0, 15);
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'd1 << $urandom_range(0, 31);
      default: return ror32(imm, 2 * r);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit          ok;
    logic [11:0] op;
    int          lat;
    int          dcount;

    rst   = 1'b1;
    start = 1'b0;
    value = 32'd0;
    #2 rst = 1'b0;
    cmp_en = 1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_operand", {20'd0, shift_operand}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Pin the model against hand-computed encodings.
    encode(32'h000000FF, ok, op, lat);
    chk("model_ff", {19'd0, ok, op}, {19'd0, 1'b1, 12'h0FF});
    encode(32'hFF000000, ok, op, lat);
    chk("model_ff000000", {19'd0, ok, op}, {19'd0, 1'b1, 12'h4FF});
    encode(32'hC000003F, ok, op, lat);
    chk("model_c000003f", {19'd0, ok, op}, {19'd0, 1'b1, 12'h1FF});
    encode(32'h00000101, ok, op, lat);
    chk("model_101", {19'd0, ok, op}, {19'd0, 1'b0, 12'h000});
    chk("model_101_lat", lat, 16);

    // Directed vectors.
    run_one(32'h000000FF, 12'h0FF, 1'b1, 1);
    run_one(32'hFF000000, 12'h4FF, 1'b1, 5);
    run_one(32'hC000003F, 12'h1FF, 1'b1, 2);
    run_one(32'h000003FC, 12'hFFF, 1'b1, 16);
    run_one(32'h00000101, 12'h000, 1'b0, 16);
    run_one(32'h00000000, 12'h000, 1'b1, 1);

    // Back-to-back: start held high through DONE, value switched to 0.
    @(posedge clk); #1;
    start = 1'b1;
    value = 32'h000000FF;
    @(posedge clk); #1;
    value = 32'h00000000;
    @(negedge clk);
    chk("b2b_busy_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_op1", {20'd0, shift_operand}, {20'd0, 12'h0FF});
    @(negedge clk);
    chk("b2b_busy_again", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_valid2", {31'd0, valid}, 32'd1);
    chk("b2b_op2", {20'd0, shift_operand}, 32'd0);
    start = 1'b0;

    // Start pulse and value change during SEARCH are ignored.
    @(posedge clk); #1;
    start = 1'b1;
    value = 32'hFF000000;
    @(posedge clk); #1;
    start = 1'b0;
    value = 32'h00000101;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ign_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_op", {20'd0, shift_operand}, {20'd0, 12'h4FF});

    // Reset abort in the middle of a no-match search.
    @(posedge clk); #1;
    start = 1'b1;
    value = 32'h00000101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_operand", {20'd0, shift_operand}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount++;
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_one(32'h000000FF, 12'h0FF, 1'b1, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) value = rand_value();
    end
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotate_imm_encoder.md
ROTATE_IMM_ENCODER -- requirements
Module: rotate_imm_encoder

Purpose: inverse of the data-processing immediate operand path. Given a 32-bit constant, search iteratively for the {rot4, imm8} encoding such that ROR(imm8, 2*rot4) equals the constant.

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request strobe; sampled on rising clk.
REQ-005 value  input  32  constant to encode; sampled only on the edge that accepts start.
REQ-006 busy  output  1  high while a search is in progress.
REQ-007 done  output  1  one-cycle pulse; result fields valid in that cycle.
REQ-008 valid  output  1  1 = constant encodable; 0 = no encoding exists.
REQ-009 shift_operand  output  12  {rot4[11:8], imm8[7:0]}; same layout the immediate decode path consumes.

Function
REQ-010 The block SHALL implement three states, IDLE, SEARCH and DONE, held in a registered state variable.
REQ-011 When start=1 in IDLE or DONE, the block SHALL load value into a 32-bit work register, clear the 4-bit rotation counter, and enter SEARCH on that edge.
REQ-012 start SHALL be ignored while in SEARCH; value changes during SEARCH SHALL have no effect.
REQ-013 On each SEARCH edge with work[31:24..8]==0 (bits 31:8 zero), the block SHALL:
  - capture shift_operand={rot, work[7:0]};
  - set valid=1;
  - enter DONE.
REQ-014 Otherwise, if rot==15, the block SHALL:
  - set valid=0 and shift_operand=12'h000;
  - enter DONE.
REQ-015 Otherwise, the block SHALL set work=ROL(work,2) and rot=rot+1, then remain in SEARCH.
REQ-016 The smallest matching rotation SHALL be reported. Value 0 encodes as 12'h000 with valid=1.
REQ-017 Latency: done SHALL be high in the cycle following edge E(k+1), where E0 is the accepting edge and k is the matched rotation; k=15 for the no-match case.
REQ-018 In DONE, done SHALL be 1 for exactly that cycle; next state is SEARCH if start=1, else IDLE.
REQ-019 busy SHALL equal (state==SEARCH).
REQ-020 valid and shift_operand SHALL hold their last result until the next DONE.
REQ-021 The rotation counter SHALL never wrap past 15 within one search.

Reset
REQ-022 When rst=0, the block SHALL immediately force IDLE, busy=0, done=0, valid=0, shift_operand=12'h000, work=0 and rot=0, independent of clk.
REQ-023 A reset asserted during SEARCH SHALL abort the search with no done pulse; operation resumes only on a fresh start after rst returns to 1.

Verification
REQ-024 value=32'h000000FF, start pulse -> done after E1, valid=1, shift_operand=12'h0FF.
REQ-025 value=32'hFF000000 -> done after E5, valid=1, shift_operand=12'h4FF; value=32'hC000003F -> done after E2, shift_operand=12'h1FF.
REQ-026 Last-rotation match and no-match:
  - value=32'h000003FC -> done after E16, valid=1, shift_operand=12'hFFF;
  - value=32'h00000101 -> done after E16, valid=0, shift_operand=12'h000.
REQ-027 Back-to-back and ignored start:
  - start held high across DONE with value=32'h0 -> second search accepted with no IDLE cycle, done after E1, shift_operand=12'h000;
  - start pulses during SEARCH are ignored.
REQ-028 Reset abort: rst pulled low mid-SEARCH while encoding 32'h00000101 -> all outputs 0 asynchronously, no done pulse; a new start then completes normally.
